// File: rtl/inst_buffer_multi.sv
// inst_buffer_multi: multi-lane show-ahead instruction buffer
// between IF and ID with zero-inst filter and squash flush.
package inst_buffer_multi_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
  } IF_IB_PACKET;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
  } IB_ID_PACKET;

endpackage

module inst_buffer_multi
  import inst_buffer_multi_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 2,
  parameter int ADDR      = $clog2(DEPTH),
  parameter int CNT_W     = $clog2(DEPTH+1)
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           squash,
  input  IF_IB_PACKET                    if_ib_packet [IN_WIDTH],
  output logic                           in_ready,
  input  logic [$clog2(OUT_WIDTH+1)-1:0] pop_count,
  output IB_ID_PACKET                    ib_id_packet [OUT_WIDTH],
  output logic [OUT_WIDTH-1:0]           out_valid,
  output logic [CNT_W-1:0]               count,
  output logic                           full,
  output logic                           empty
);

  localparam int PSH_W = $clog2(IN_WIDTH+1);

  IF_IB_PACKET      r_mem [DEPTH];
  logic [ADDR-1:0]  r_head;
  logic [ADDR-1:0]  r_tail;
  logic [CNT_W-1:0] r_count;

  logic [IN_WIDTH-1:0] w_keep;
  logic [PSH_W-1:0]    w_off [IN_WIDTH];
  logic [ADDR-1:0]     w_waddr [IN_WIDTH];
  logic [ADDR-1:0]     w_raddr [OUT_WIDTH];
  logic [PSH_W-1:0]    w_push_n;
  logic [CNT_W-1:0]    w_push_cnt;
  logic [CNT_W-1:0]    w_pop_eff;
  logic                w_in_ready;
  logic                w_push_en;

  // keep a lane only if it is valid and not an all-zero encoding
  always_comb begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      w_keep[i] = if_ib_packet[i].valid &&
                  (if_ib_packet[i].inst != 32'h0);
    end
  end

  // compaction: each kept lane's slot is the number of kept lanes before it
  always_comb begin
    w_push_n = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      w_off[i]   = w_push_n;
      w_waddr[i] = r_tail + ADDR'(w_push_n);
      w_push_n   = w_push_n + PSH_W'(w_keep[i]);
    end
  end

  // whole-group space check from registered occupancy only
  assign w_in_ready = (int'(r_count) + IN_WIDTH) <= DEPTH;
  assign w_push_en  = w_in_ready && !squash;
  assign w_push_cnt = w_push_en ? CNT_W'(w_push_n) : '0;

  // clamp decode's pop request to what is actually held
  always_comb begin
    w_pop_eff = CNT_W'(pop_count);
    if (int'(pop_count) > int'(r_count)) begin
      w_pop_eff = r_count;
    end
  end

  // pointer and occupancy state; squash flushes, reset clears at once
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (squash) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + ADDR'(w_pop_eff);
      r_tail  <= r_tail + ADDR'(w_push_cnt);
      r_count <= r_count + w_push_cnt - w_pop_eff;
    end
  end

  // storage write: kept lanes land contiguously from tail, wrapping
  always_ff @(posedge clock) begin
    if (w_push_en) begin
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (w_keep[i]) begin
          r_mem[w_waddr[i]] <= if_ib_packet[i];
        end
      end
    end
  end

  // show-ahead read window starting at head, zeroed past occupancy
  always_comb begin
    for (int i = 0; i < OUT_WIDTH; i++) begin
      w_raddr[i]      = r_head + ADDR'(i);
      out_valid[i]    = i < int'(r_count);
      ib_id_packet[i] = '0;
      if (out_valid[i]) begin
        ib_id_packet[i].valid = r_mem[w_raddr[i]].valid;
        ib_id_packet[i].inst  = r_mem[w_raddr[i]].inst;
        ib_id_packet[i].pc    = r_mem[w_raddr[i]].pc;
      end
    end
  end

  assign in_ready = w_in_ready;
  assign count    = r_count;
  assign full     = r_count == CNT_W'(DEPTH);
  assign empty    = r_count == '0;

endmodule

// File: tb/tb_inst_buffer_multi.sv
// tb_inst_buffer_multi: directed + random checks of
// inst_buffer_multi against a queue-based reference.
module tb_inst_buffer_multi;
  import inst_buffer_multi_pkg::*;

  localparam int DEPTH = 16;
  localparam int INW   = 2;
  localparam int OUTW  = 2;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PCW   = $clog2(OUTW+1);

  logic              clock;
  logic              reset_n;
  logic              squash;
  IF_IB_PACKET       lanes [INW];
  logic              in_ready;
  logic [PCW-1:0]    pop_count;
  IB_ID_PACKET       ib_id_packet [OUTW];
  logic [OUTW-1:0]   out_valid;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  IF_IB_PACKET mq [$];
  int n_chk;
  int n_fail;
  int unsigned pcn;

  inst_buffer_multi #(
    .DEPTH(DEPTH),
    .IN_WIDTH(INW),
    .OUT_WIDTH(OUTW)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .squash(squash),
    .if_ib_packet(lanes),
    .in_ready(in_ready),
    .pop_count(pop_count),
    .ib_id_packet(ib_id_packet),
    .out_valid(out_valid),
    .count(count),
    .full(full),
    .empty(empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic IF_IB_PACKET mk(logic v, logic [31:0] i,
                                     logic [31:0] p);
    IF_IB_PACKET k;
    k.valid = v;
    k.inst  = i;
    k.pc    = p;
    return k;
  endfunction

  task automatic clr_lanes();
    for (int l = 0; l < INW; l++) lanes[l] = '0;
  endtask

  // a full group of fresh, valid, nonzero instructions
  task automatic next_group();
    for (int l = 0; l < INW; l++) begin
      lanes[l] = mk(1'b1, 32'h13 | (pcn << 8), pcn);
      pcn += 4;
    end
  endtask

  task automatic chk(string tag, logic [127:0] obs,
                     logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: queue of held entries, oldest at the front
  task automatic tick();
    int sz;
    int pe;
    sz = mq.size();
    if (squash) begin
      mq.delete();
    end else begin
      pe = int'(pop_count);
      if (pe > sz) pe = sz;
      for (int k = 0; k < pe; k++) void'(mq.pop_front());
      if (DEPTH - sz >= INW) begin
        for (int l = 0; l < INW; l++)
          if (lanes[l].valid && lanes[l].inst != 32'h0)
            mq.push_back(lanes[l]);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_state(string tag);
    int sz;
    logic [OUTW-1:0] ev;
    IB_ID_PACKET ep;
    sz = mq.size();
    chk({tag, ":count"}, 128'(count), 128'(sz));
    chk({tag, ":full"}, 128'(full), 128'(sz == DEPTH));
    chk({tag, ":empty"}, 128'(empty), 128'(sz == 0));
    chk({tag, ":in_ready"}, 128'(in_ready),
        128'(DEPTH - sz >= INW));
    for (int i = 0; i < OUTW; i++) ev[i] = i < sz;
    chk({tag, ":out_valid"}, 128'(out_valid), 128'(ev));
    for (int i = 0; i < OUTW; i++) begin
      ep = '0;
      if (i < sz) begin
        ep.valid = 1'b1;
        ep.inst  = mq[i].inst;
        ep.pc    = mq[i].pc;
      end
      chk($sformatf("%s:lane%0d", tag, i),
          128'(ib_id_packet[i]), 128'(ep));
    end
  endtask

  initial begin
    int p;
    int sz;
    n_chk = 0;
    n_fail = 0;
    pcn = 32'h100;
    reset_n = 1'b0;
    squash = 1'b1;
    pop_count = '0;
    clr_lanes();

    #12;
    check_state("reset");
    chk("reset:in_ready1", 128'(in_ready), 128'(1));
    @(negedge clock);
    reset_n = 1'b1;
    squash = 1'b0;

    lanes[0] = mk(1'b1, 32'h00100013, 32'h0);
    lanes[1] = mk(1'b1, 32'h00200013, 32'h4);
    tick();
    check_state("fill");
    chk("fill:pc0", 128'(ib_id_packet[0].pc), 128'(0));
    chk("fill:vld", 128'(out_valid), 128'(2'b11));

    lanes[0] = mk(1'b1, 32'h0, 32'h10);
    lanes[1] = mk(1'b1, 32'h00000013, 32'h8);
    pop_count = PCW'(2);
    tick();
    check_state("filter");
    chk("filter:pc8", 128'(ib_id_packet[0].pc), 128'(8));
    chk("filter:cnt1", 128'(count), 128'(1));

    clr_lanes();
    pop_count = PCW'(1);
    tick();
    pop_count = '0;
    for (int g = 0; g < 8; g++) begin
      next_group();
      tick();
    end
    check_state("full");
    chk("full:cnt16", 128'(count), 128'(16));
    chk("full:rdy0", 128'(in_ready), 128'(0));
    next_group();
    tick();
    check_state("full_hold");
    pop_count = PCW'(1);
    tick();
    check_state("pop15");
    chk("pop15:rdy0", 128'(in_ready), 128'(0));
    tick();
    check_state("pop14");
    chk("pop14:rdy1", 128'(in_ready), 128'(1));

    clr_lanes();
    pop_count = '0;
    squash = 1'b1;
    tick();
    squash = 1'b0;
    for (int g = 0; g < 8; g++) begin
      next_group();
      tick();
    end
    clr_lanes();
    pop_count = PCW'(2);
    for (int g = 0; g < 7; g++) tick();
    check_state("pre_wrap");
    next_group();
    tick();
    check_state("wrap");
    chk("wrap:pc", 128'(ib_id_packet[0].pc), 128'(pcn - 8));

    clr_lanes();
    pop_count = '0;
    squash = 1'b1;
    tick();
    squash = 1'b0;
    next_group();
    tick();
    next_group();
    tick();
    next_group();
    lanes[1] = '0;
    tick();
    check_state("five");
    next_group();
    squash = 1'b1;
    pop_count = PCW'(1);
    tick();
    check_state("squash");
    chk("squash:empty", 128'(empty), 128'(1));
    squash = 1'b0;
    pop_count = '0;
    next_group();
    lanes[1] = '0;
    tick();
    check_state("post_sq");

    for (int g = 0; g < 3; g++) begin
      next_group();
      tick();
    end
    clr_lanes();
    check_state("seven");
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    mq.delete();
    check_state("async_rst");
    @(negedge clock);
    reset_n = 1'b1;
    next_group();
    tick();
    check_state("post_rst");

    for (int c = 0; c < 400; c++) begin
      for (int l = 0; l < INW; l++) begin
        lanes[l].valid = $urandom_range(0, 3) != 0;
        lanes[l].inst  = ($urandom_range(0, 4) == 0) ?
                         32'h0 : ($urandom() | 32'h1);
        lanes[l].pc    = $urandom();
      end
      sz = mq.size();
      p = $urandom_range(0, (sz < OUTW) ? sz : OUTW);
      pop_count = PCW'(p);
      squash = $urandom_range(0, 39) == 0;
      tick();
      check_state("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
